// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback requesters.
// Optional macro REGFILE_WB_ZERO_REG_EN: accepted writes to register 0 are dropped (reg_write=0).
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned REGADDR_WIDTH = 3,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*REGADDR_WIDTH-1:0] req_reg,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             wb_stall,
  output logic                             reg_write,
  output logic [REGADDR_WIDTH-1:0]         write_reg,
  output logic [DATA_WIDTH-1:0]            write_data,
  output logic [NUM_REQ-1:0]               last_grant,
  output logic [CNT_WIDTH-1:0]             contention_cnt
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                     reg_write_q, reg_write_d;
  logic [REGADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic [NUM_REQ-1:0]       last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]     contention_cnt_q, contention_cnt_d;

  logic                     hi_found, lo_found, seen, multi_valid;
  logic [PtrW-1:0]          hi_idx, lo_idx, gnt_idx;
  logic                     any_valid, accept, issue_write;
  logic [NUM_REQ-1:0]       gnt_oh;
  logic [REGADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0]    sel_data;

  // Wrapped search from rr_ptr: first valid at/above the pointer, else first valid overall.
  always_comb begin
    hi_found    = 1'b0;
    lo_found    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    seen        = 1'b0;
    multi_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (seen) begin
          multi_valid = 1'b1;
        end
        seen = 1'b1;
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = PtrW'(i);
        end
        if (!hi_found && (i >= 32'(rr_ptr_q))) begin
          hi_found = 1'b1;
          hi_idx   = PtrW'(i);
        end
      end
    end
  end

  assign any_valid = lo_found;
  assign gnt_idx   = hi_found ? hi_idx : lo_idx;
  assign accept    = any_valid & ~wb_stall;

  always_comb begin
    gnt_oh   = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PtrW'(i)) begin
        gnt_oh[i] = 1'b1;
        sel_reg   = req_reg[i*REGADDR_WIDTH +: REGADDR_WIDTH];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready depends only on the request side, never on the staged output.
  assign req_ready = accept ? gnt_oh : '0;

`ifdef REGFILE_WB_ZERO_REG_EN
  assign issue_write = (sel_reg != '0);
`else
  assign issue_write = 1'b1;
`endif

  always_comb begin
    rr_ptr_d         = rr_ptr_q;
    reg_write_d      = 1'b0;
    write_reg_d      = write_reg_q;
    write_data_d     = write_data_q;
    last_grant_d     = last_grant_q;
    contention_cnt_d = contention_cnt_q;
    if (accept) begin
      reg_write_d  = issue_write;
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
      last_grant_d = gnt_oh;
      rr_ptr_d     = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (multi_valid && (contention_cnt_q != {CNT_WIDTH{1'b1}})) begin
        contention_cnt_d = contention_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q         <= '0;
      reg_write_q      <= 1'b0;
      write_reg_q      <= '0;
      write_data_q     <= '0;
      last_grant_q     <= '0;
      contention_cnt_q <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      reg_write_q      <= reg_write_d;
      write_reg_q      <= write_reg_d;
      write_data_q     <= write_data_d;
      last_grant_q     <= last_grant_d;
      contention_cnt_q <= contention_cnt_d;
    end
  end

  assign reg_write      = reg_write_q;
  assign write_reg      = write_reg_q;
  assign write_data     = write_data_q;
  assign last_grant     = last_grant_q;
  assign contention_cnt = contention_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a behavioural round-robin model.
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 8;
  localparam int CntMax = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NR-1:0]        req_valid = '0;
  logic [NR*AW-1:0]     req_reg = '0;
  logic [NR*DW-1:0]     req_data = '0;
  logic [NR-1:0]        req_ready;
  logic                 wb_stall = 1'b0;
  logic                 reg_write;
  logic [AW-1:0]        write_reg;
  logic [DW-1:0]        write_data;
  logic [NR-1:0]        last_grant;
  logic [CW-1:0]        contention_cnt;

  int tests = 0;
  int fails = 0;

  // Model state
  int            m_ptr;
  logic          m_rw;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_wd;
  logic [NR-1:0] m_lg;
  int            m_cnt;
  int            p_g;
  bit            p_acc;
  logic [NR-1:0] exp_ready;

  regfile_wb_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .REGADDR_WIDTH(AW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .wb_stall      (wb_stall),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .last_grant    (last_grant),
    .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  function automatic int model_grant(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_rw = 1'b0; m_wr = '0; m_wd = '0; m_lg = '0; m_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; wb_stall = 1'b0;
    #3;
    model_reset();
    reset = 1'b0;
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR*AW-1:0] r,
                       input logic [NR*DW-1:0] d, input logic s);
    req_valid = v; req_reg = r; req_data = d; wb_stall = s;
    #1;
    p_g = model_grant(v, m_ptr);
    p_acc = (p_g >= 0) && !s;
    exp_ready = '0;
    if (p_acc) exp_ready[p_g] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (p_acc) begin
      m_wr = req_reg[p_g*AW +: AW];
      m_wd = req_data[p_g*DW +: DW];
      m_rw = 1'b1;
`ifdef REGFILE_WB_ZERO_REG_EN
      if (m_wr == '0) m_rw = 1'b0;
`endif
      m_lg = exp_ready;
      m_ptr = (p_g + 1) % NR;
      if ($countones(req_valid) >= 2 && m_cnt < CntMax) m_cnt++;
    end else begin
      m_rw = 1'b0;
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({reg_write, write_reg, write_data, last_grant, contention_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_state: got %b/%h/%h/%b/%0d want all zero", reg_write, write_reg,
               write_data, last_grant, contention_cnt);
    end
    tests++;
    if (req_ready !== '0) begin
      fails++;
      $display("FAIL reset_ready: got %b want 000", req_ready);
    end
  endtask

  task automatic test_reset_traffic();
    do_reset();
    drive(3'b110, {3'd6, 3'd2, 3'd0}, {16'hCAFE, 16'h1111, 16'h0}, 1'b0);
    tick();
    drive(3'b100, {3'd6, 3'd2, 3'd0}, {16'hCAFE, 16'h1111, 16'h0}, 1'b0);
    tick();
    tests++;
    if (reg_write !== 1'b1 || write_data !== 16'hCAFE) begin
      fails++;
      $display("FAIL rst_traffic_staged: got %b/%h want 1/cafe", reg_write, write_data);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({reg_write, write_reg, write_data, last_grant, contention_cnt} !== '0) begin
      fails++;
      $display("FAIL rst_traffic_async: got %b/%h/%h/%b/%0d want all zero", reg_write,
               write_reg, write_data, last_grant, contention_cnt);
    end
    @(posedge clk);
    #1;
    tests++;
    if (reg_write !== 1'b0) begin
      fails++;
      $display("FAIL rst_traffic_nowrite: got %b want 0", reg_write);
    end
    model_reset();
    reset = 1'b0;
    drive(3'b111, {3'd3, 3'd2, 3'd1}, {16'h3333, 16'h2222, 16'h1111}, 1'b0);
    tests++;
    if (req_ready !== 3'b001) begin
      fails++;
      $display("FAIL rst_traffic_first_grant: got %b want 001", req_ready);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    drive(3'b010, {3'd0, 3'd5, 3'd0}, {16'h0, 16'hBEEF, 16'h0}, 1'b0);
    tests++;
    if (req_ready !== 3'b010) begin
      fails++;
      $display("FAIL single_ready: got %b want 010", req_ready);
    end
    tick();
    tests++;
    if ({reg_write, write_reg, write_data, last_grant, contention_cnt} !==
        {1'b1, 3'd5, 16'hBEEF, 3'b010, 8'd0}) begin
      fails++;
      $display("FAIL single_out: got %b/%0d/%h/%b/%0d want 1/5/beef/010/0", reg_write,
               write_reg, write_data, last_grant, contention_cnt);
    end
    // A lone requester wins again even though the pointer moved past it.
    drive(3'b010, {3'd0, 3'd5, 3'd0}, {16'h0, 16'hBEEF, 16'h0}, 1'b0);
    tests++;
    if (req_ready !== 3'b010) begin
      fails++;
      $display("FAIL single_repeat: got %b want 010", req_ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] oh;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, (NR*AW)'($urandom), (NR*DW)'({$urandom, $urandom}), 1'b0);
      oh = '0;
      oh[i % NR] = 1'b1;
      tests++;
      if (req_ready !== oh) begin
        fails++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, oh);
      end
      tick();
      tests++;
      if ({reg_write, write_reg, write_data, last_grant} !== {m_rw, m_wr, m_wd, oh}) begin
        fails++;
        $display("FAIL rr_out[%0d]: got %b/%0d/%h/%b want %b/%0d/%h/%b", i, reg_write,
                 write_reg, write_data, last_grant, m_rw, m_wr, m_wd, oh);
      end
    end
    tests++;
    if (contention_cnt !== 8'd6) begin
      fails++;
      $display("FAIL rr_contention: got %0d want 6", contention_cnt);
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    drive(3'b010, {3'd0, 3'd4, 3'd0}, {16'h0, 16'h4444, 16'h0}, 1'b0);
    tick();
    drive(3'b011, {3'd0, 3'd4, 3'd7}, {16'h0, 16'h4444, 16'h7777}, 1'b0);
    tests++;
    if (req_ready !== 3'b001) begin
      fails++;
      $display("FAIL wrap_grant0: got %b want 001", req_ready);
    end
    tick();
    tests++;
    if (write_reg !== 3'd7 || write_data !== 16'h7777 || last_grant !== 3'b001) begin
      fails++;
      $display("FAIL wrap_out0: got %0d/%h/%b want 7/7777/001", write_reg, write_data,
               last_grant);
    end
    drive(3'b010, {3'd0, 3'd4, 3'd7}, {16'h0, 16'h4444, 16'h7777}, 1'b0);
    tests++;
    if (req_ready !== 3'b010) begin
      fails++;
      $display("FAIL wrap_grant1: got %b want 010", req_ready);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [CW-1:0] cnt_before;
    do_reset();
    drive(3'b011, {3'd0, 3'd1, 3'd2}, {16'h0, 16'hAAAA, 16'h5555}, 1'b0);
    tick();
    cnt_before = contention_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(3'b101, {3'd3, 3'd0, 3'd2}, {16'h3030, 16'h0, 16'h5555}, 1'b1);
      tests++;
      if (req_ready !== 3'b000) begin
        fails++;
        $display("FAIL stall_ready[%0d]: got %b want 000", i, req_ready);
      end
      tick();
      tests++;
      if (reg_write !== 1'b0 || contention_cnt !== cnt_before) begin
        fails++;
        $display("FAIL stall_out[%0d]: got %b/%0d want 0/%0d", i, reg_write, contention_cnt,
                 cnt_before);
      end
    end
    // Pointer held at 1, so the search skips invalid 1 and picks 2.
    drive(3'b101, {3'd3, 3'd0, 3'd2}, {16'h3030, 16'h0, 16'h5555}, 1'b0);
    tests++;
    if (req_ready !== 3'b100) begin
      fails++;
      $display("FAIL stall_resume: got %b want 100", req_ready);
    end
    tick();
    tests++;
    if ({reg_write, write_reg, write_data, contention_cnt} !== {1'b1, 3'd3, 16'h3030, 8'd2}) begin
      fails++;
      $display("FAIL stall_resume_out: got %b/%0d/%h/%0d want 1/3/3030/2", reg_write,
               write_reg, write_data, contention_cnt);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(3'b001, {3'd0, 3'd0, 3'd0}, {16'h0, 16'h0, 16'h1234}, 1'b0);
    tests++;
    if (req_ready !== 3'b001) begin
      fails++;
      $display("FAIL zero_ready: got %b want 001", req_ready);
    end
    tick();
`ifdef REGFILE_WB_ZERO_REG_EN
    tests++;
    if (reg_write !== 1'b0 || last_grant !== 3'b001) begin
      fails++;
      $display("FAIL zero_out: got %b/%b want 0/001", reg_write, last_grant);
    end
`else
    tests++;
    if ({reg_write, write_reg, write_data} !== {1'b1, 3'd0, 16'h1234}) begin
      fails++;
      $display("FAIL zero_out: got %b/%0d/%h want 1/0/1234", reg_write, write_reg, write_data);
    end
`endif
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(3'b111, (NR*AW)'($urandom), (NR*DW)'({$urandom, $urandom}), 1'b0);
      tick();
    end
    tests++;
    if (contention_cnt !== 8'hFF || m_cnt != CntMax) begin
      fails++;
      $display("FAIL saturate: got %0d want 255", contention_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(NR'($urandom), (NR*AW)'($urandom), (NR*DW)'({$urandom, $urandom}),
            ($urandom_range(0, 7) == 0));
      tests++;
      if (req_ready !== exp_ready) begin
        fails++;
        $display("FAIL rand_ready[%0d]: got %b want %b", i, req_ready, exp_ready);
      end
      tick();
      tests++;
      if ({reg_write, write_reg, write_data, last_grant, contention_cnt} !==
          {m_rw, m_wr, m_wd, m_lg, CW'(m_cnt)}) begin
        fails++;
        $display("FAIL rand_out[%0d]: got %b/%0d/%h/%b/%0d want %b/%0d/%h/%b/%0d", i,
                 reg_write, write_reg, write_data, last_grant, contention_cnt, m_rw, m_wr,
                 m_wd, m_lg, m_cnt);
      end
    end
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    reset = 1'b0;
    #2;
    test_reset_traffic();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_stall();
    test_zero_reg();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback requesters, for example the ALU, load unit and multiplier.
- Uses round-robin arbitration with a per-requester valid/ready handshake.
- Drives reg_write/write_reg/write_data of the register file from registered outputs.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_WIDTH, 16, register data width; must match the register file.
- REGADDR_WIDTH, 3, register address width; must match the register file.
- CNT_WIDTH, 8, width of the saturating contention counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i has a pending write.
- req_reg  input  NUM_REQ*REGADDR_WIDTH  slice i = destination register of requester i.
- req_data  input  NUM_REQ*DATA_WIDTH  slice i = write data of requester i.
- req_ready  output  NUM_REQ  bit i: requester i's write is accepted this cycle.
- wb_stall  input  1  freeze arbitration; no request accepted while high.
- reg_write  output  1  register file write enable (registered).
- write_reg  output  REGADDR_WIDTH  register file write address (registered).
- write_data  output  DATA_WIDTH  register file write data (registered).
- last_grant  output  NUM_REQ  one-hot index of the most recently accepted requester (registered).
- contention_cnt  output  CNT_WIDTH  saturating count of accept cycles with more than one valid request.

Behaviour:
- Reset is asynchronous. While reset is high:
  - rr_ptr=0.
  - reg_write=0, write_reg=0, write_data=0.
  - last_grant=0, contention_cnt=0.
- Any write staged in the output register when reset asserts is discarded, not retried.
- Requester i's request is held, with req_reg/req_data stable, from valid high until the cycle req_ready[i]=1. The arbiter does not check this.
- Grant logic is combinational:
  - Search req_valid starting at index rr_ptr and ascending with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - The first valid index g is granted.
  - req_ready is one-hot at g when any req_valid=1 and wb_stall=0; otherwise req_ready=0.
  - req_ready never depends on reg_write or on any output-side state.
- Accept in cycle t (req_ready[g]=1):
  - At the edge ending cycle t: reg_write<=1, write_reg<=req_reg slice g, write_data<=req_data slice g, last_grant<=one-hot(g).
  - rr_ptr<=(g+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
  - The register file therefore writes at the edge ending cycle t+1. Latency request-to-regfile-write is 2 edges.
- No accept in a cycle:
  - reg_write<=0.
  - write_reg, write_data, last_grant and rr_ptr hold.
- wb_stall=1: no accept. reg_write<=0 at the next edge, so a write already staged still completes this cycle. rr_ptr holds.
- Contention counter:
  - contention_cnt increments by 1 on every accept cycle where popcount(req_valid)>=2.
  - It saturates at all-ones with no wrap.
  - Stalled cycles are not counted.
- Throughput is one write per cycle. With all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- A single valid requester is granted every cycle regardless of rr_ptr.
- Same-register writes by different requesters are serialised in grant order. The later grant wins in the register file.

Optional Feature:
- Macro: REGFILE_WB_ZERO_REG_EN.
- Defined: a request whose req_reg==0 is accepted normally. It takes req_ready and advances rr_ptr and last_grant, but is issued with reg_write<=0, so register 0 is never written. It still counts toward contention_cnt.
- Undefined: register 0 is an ordinary register and is written like any other.

Test Plan:
- Reset during traffic:
  - Stimulus: drive reset high mid-stream with a write staged.
  - Required response: reg_write, write_reg, write_data, last_grant and contention_cnt read 0 immediately (asynchronous). No regfile write occurs. After release the first grant goes to requester 0.
- Single requester:
  - Stimulus: req_valid=3'b010, req_reg slice1=5, req_data slice1=16'hBEEF for 1 cycle.
  - Required response: req_ready=3'b010 that cycle. Next cycle reg_write=1, write_reg=5, write_data=16'hBEEF, last_grant=3'b010. contention_cnt stays 0.
- Round-robin fairness:
  - Stimulus: req_valid=3'b111 held 6 cycles after reset.
  - Required response: grant sequence 0,1,2,0,1,2. contention_cnt=6.
- Wrap and skip:
  - Stimulus: rr_ptr=2 (after granting 1) with req_valid=3'b011.
  - Required response: grant 0 (wrap, skipping invalid 2), then grant 1.
- Stall:
  - Stimulus: wb_stall=1 for 3 cycles with req_valid=3'b101.
  - Required response: req_ready=0 and reg_write=0 throughout. rr_ptr and contention_cnt unchanged. On release, arbitration resumes from the held pointer.
- Zero register, REGFILE_WB_ZERO_REG_EN defined:
  - Stimulus: req_reg=0, data=16'h1234.
  - Required response: req_ready=1, next cycle reg_write=0, last_grant updated.
- Zero register, REGFILE_WB_ZERO_REG_EN undefined:
  - Stimulus: the same request.
  - Required response: reg_write=1, write_reg=0, write_data=16'h1234.
